// File: rtl/csr_pkg.sv
// Shared CSR addresses, operation encoding, cause codes and mstatus bit positions
// for the machine-mode CSR/trap unit.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK  = 5'd3;
  localparam logic [4:0] CAUSE_ECALL   = 5'd11;
  localparam logic [4:0] CAUSE_MTI     = 5'd7;

  // Bit positions inside mip/mie; local line i sits at IRQ_LOCAL_BASE + i.
  localparam int IRQ_MTI_BIT    = 7;
  localparam int IRQ_LOCAL_BASE = 16;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/csr_trap_unit_irq_sync.sv
// Two-flop synchroniser for asynchronous level interrupt lines.
// Latency: 2 clk edges; no backpressure.
module irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file, interrupt/exception arbitration and trap/MRET redirect.
// Latency: reads and redirect are combinational, state updates at the next edge; no backpressure.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic [XLEN-1:0]    pc,
  input  logic               instret,
  input  logic               ecall,
  input  logic               ebreak,
  input  logic               illegal,
  input  logic               is_mret,
  input  logic [NUM_IRQ-1:0] irq_ext,
  input  logic               irq_timer,
  output logic               trap_taken,
  output logic               redirect,
  output logic [XLEN-1:0]    redirect_pc
);

  localparam logic [XLEN-1:0] LOW2_MASK    = XLEN'(3);
  localparam logic [XLEN-1:0] MTVEC_MASK   = ~XLEN'(2);
  localparam logic [XLEN-1:0] MSTATUS_MASK =
    XLEN'((64'(1) << MSTATUS_MIE_BIT) | (64'(1) << MSTATUS_MPIE_BIT));
  localparam logic [XLEN-1:0] MIE_MASK =
    XLEN'((64'(1) << IRQ_MTI_BIT) | (((64'(1) << NUM_IRQ) - 64'(1)) << IRQ_LOCAL_BASE));

  logic [NUM_IRQ:0]  irq_raw;
  logic [NUM_IRQ:0]  irq_synced;

  logic [XLEN-1:0]   mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0]       mcycle_q, minstret_q;
  logic [63:0]       mcycle_d, minstret_d;
  logic [XLEN-1:0]   mip;
  logic [XLEN-1:0]   irq_pend;
  logic              irq_any;
  logic [4:0]        irq_code;
  logic [4:0]        exc_code;
  logic [4:0]        trap_code;
  logic [XLEN-1:0]   trap_cause;
  logic [XLEN-1:0]   tvec_base;
  logic              mret_taken;
  logic              csr_we;
  logic [XLEN-1:0]   csr_new;

  // Bit 0 carries the timer line, bits 1..NUM_IRQ the local lines.
  assign irq_raw = {irq_ext, irq_timer};

  irq_sync #(.WIDTH(NUM_IRQ + 1)) u_irq_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (irq_raw),
    .q     (irq_synced)
  );

  always_comb begin
    mip = '0;
    mip[IRQ_MTI_BIT] = irq_synced[0];
    mip[IRQ_LOCAL_BASE +: NUM_IRQ] = irq_synced[NUM_IRQ:1];
  end

  // MTI outranks every local line; among local lines the lowest index wins.
  always_comb begin
    irq_pend = mip & mie_q & {XLEN{mstatus_q[MSTATUS_MIE_BIT]}};
    irq_any  = |irq_pend;
    irq_code = CAUSE_MTI;
    if (!irq_pend[IRQ_MTI_BIT]) begin
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
        if (irq_pend[IRQ_LOCAL_BASE + i]) irq_code = 5'(IRQ_LOCAL_BASE + i);
      end
    end
  end

  always_comb begin
    if (illegal)     exc_code = CAUSE_ILLEGAL;
    else if (ebreak) exc_code = CAUSE_EBREAK;
    else             exc_code = CAUSE_ECALL;
  end

  assign trap_taken = irq_any | illegal | ebreak | ecall;
  assign trap_code  = irq_any ? irq_code : exc_code;
  assign trap_cause = {irq_any, {(XLEN-6){1'b0}}, trap_code};
  assign mret_taken = is_mret & ~trap_taken;
  assign redirect   = trap_taken | mret_taken;
  assign tvec_base  = mtvec_q & ~LOW2_MASK;

  always_comb begin
    if (trap_taken) begin
      if (mtvec_q[0] && irq_any) redirect_pc = tvec_base + XLEN'({trap_code, 2'b00});
      else                       redirect_pc = tvec_base;
    end else begin
      redirect_pc = mepc_q;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_q;
      CSR_MIE:       csr_rdata = mie_q;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MIP:       csr_rdata = mip;
      CSR_MCYCLE:    csr_rdata = XLEN'(mcycle_q[31:0]);
      CSR_MCYCLEH:   csr_rdata = XLEN'(mcycle_q[63:32]);
      CSR_MINSTRET:  csr_rdata = XLEN'(minstret_q[31:0]);
      CSR_MINSTRETH: csr_rdata = XLEN'(minstret_q[63:32]);
      default:       csr_rdata = '0;
    endcase
  end

  always_comb begin
    case (csr_op_e'(csr_op))
      CSR_OP_RS: csr_new = csr_rdata | csr_wdata;
      CSR_OP_RC: csr_new = csr_rdata & ~csr_wdata;
      default:   csr_new = csr_wdata;
    endcase
  end

  // A trapping instruction is squashed, so its CSR write never lands.
  assign csr_we = (csr_op_e'(csr_op) != CSR_OP_NONE) && !trap_taken;

  // An explicit counter write replaces that cycle's increment.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + ((instret && !trap_taken) ? 64'd1 : 64'd0);
    if (csr_we) begin
      case (csr_addr)
        CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], 32'(csr_new)};
        CSR_MCYCLEH:   mcycle_d   = {32'(csr_new), mcycle_q[31:0]};
        CSR_MINSTRET:  minstret_d = {minstret_q[63:32], 32'(csr_new)};
        CSR_MINSTRETH: minstret_d = {32'(csr_new), minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET & MTVEC_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (trap_taken) begin
        mepc_q   <= pc & ~LOW2_MASK;
        mcause_q <= trap_cause;
        mstatus_q[MSTATUS_MPIE_BIT] <= mstatus_q[MSTATUS_MIE_BIT];
        mstatus_q[MSTATUS_MIE_BIT]  <= 1'b0;
      end else if (mret_taken) begin
        mstatus_q[MSTATUS_MIE_BIT]  <= mstatus_q[MSTATUS_MPIE_BIT];
        mstatus_q[MSTATUS_MPIE_BIT] <= 1'b1;
      end
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS:  mstatus_q  <= csr_new & MSTATUS_MASK;
          CSR_MIE:      mie_q      <= csr_new & MIE_MASK;
          CSR_MTVEC:    mtvec_q    <= csr_new & MTVEC_MASK;
          CSR_MSCRATCH: mscratch_q <= csr_new;
          CSR_MEPC:     mepc_q     <= csr_new & ~LOW2_MASK;
          CSR_MCAUSE:   mcause_q   <= csr_new;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed plus randomized bench for csr_trap_unit against a behavioural CSR/trap model.
module tb_csr_trap_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0200;
  localparam logic [31:0] MIE_WMASK = 32'h000F_0080;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] pc;
  logic        instret, ecall, ebreak, illegal, is_mret;
  logic [3:0]  irq_ext;
  logic        irq_timer;
  logic        trap_taken, redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  csr_trap_unit #(.XLEN(32), .NUM_IRQ(4), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .pc(pc), .instret(instret), .ecall(ecall), .ebreak(ebreak),
    .illegal(illegal), .is_mret(is_mret), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .trap_taken(trap_taken), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: architectural CSR values plus a history of sampled irq inputs.
  logic        m_ie, m_pie;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cycle, m_instret;
  logic [4:0]  irq_hist[$];
  logic        cap_trap, cap_redirect;
  logic [31:0] cap_rdata, cap_rpc;

  logic [11:0] rd_addr [13] = '{12'hB00, 12'h300, 12'h304, 12'hB00, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h344, 12'hB80, 12'hB02, 12'hB82, 12'h123};
  logic [31:0] rd_exp  [13] = '{32'd0, 32'd0, 32'd0, 32'd3, MTVEC_RST, 32'd0, 32'd0,
                                32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
  logic [11:0] rnd_addr [14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h123, 12'hB03, 12'h300};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_mip();
    logic [31:0] v;
    logic [4:0]  s;
    s = irq_hist[1];
    v = 32'd0;
    v[7] = s[0];
    for (int i = 0; i < 4; i++) v[16 + i] = s[i + 1];
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_ie) << 3) | (32'(m_pie) << 7);
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip();
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_ie = 0; m_pie = 0; m_mie = 0; m_mtvec = MTVEC_RST; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_cycle = 0; m_instret = 0;
    irq_hist.delete();
    irq_hist.push_back(5'd0);
    irq_hist.push_back(5'd0);
  endtask

  task automatic m_expect(output logic trap, output logic is_irq, output int code,
                          output logic redir, output logic [31:0] rpc);
    logic [31:0] pend;
    logic [31:0] base;
    pend   = m_mip() & m_mie & {32{m_ie}};
    is_irq = (pend != 0);
    code   = 0;
    if (is_irq) begin
      if (pend[7]) code = 7;
      else for (int b = 31; b >= 16; b--) if (pend[b]) code = b;
    end else if (illegal) code = 2;
    else if (ebreak) code = 3;
    else if (ecall) code = 11;
    trap  = is_irq || illegal || ebreak || ecall;
    redir = trap || is_mret;
    base  = {m_mtvec[31:2], 2'b00};
    if (trap) rpc = (m_mtvec[0] && is_irq) ? base + 32'(4 * code) : base;
    else      rpc = m_mepc;
  endtask

  task automatic m_commit();
    logic trap, is_irq, redir, cyc_w, ins_w;
    int code;
    logic [31:0] rpc, oldv, newv;
    cyc_w = 0;
    ins_w = 0;
    m_expect(trap, is_irq, code, redir, rpc);
    if (trap) begin
      m_mepc   = pc & ~32'h3;
      m_mcause = (is_irq ? 32'h8000_0000 : 32'h0) | 32'(code);
      m_pie    = m_ie;
      m_ie     = 0;
    end else if (is_mret) begin
      m_ie  = m_pie;
      m_pie = 1;
    end
    if (!trap && csr_op != 2'b00) begin
      oldv = m_read(csr_addr);
      newv = (csr_op == 2'b01) ? csr_wdata : (csr_op == 2'b10) ? (oldv | csr_wdata) : (oldv & ~csr_wdata);
      case (csr_addr)
        12'h300: begin m_ie = newv[3]; m_pie = newv[7]; end
        12'h304: m_mie = newv & MIE_WMASK;
        12'h305: m_mtvec = newv & ~32'h2;
        12'h340: m_mscratch = newv;
        12'h341: m_mepc = newv & ~32'h3;
        12'h342: m_mcause = newv;
        12'hB00: begin m_cycle[31:0] = newv; cyc_w = 1; end
        12'hB80: begin m_cycle[63:32] = newv; cyc_w = 1; end
        12'hB02: begin m_instret[31:0] = newv; ins_w = 1; end
        12'hB82: begin m_instret[63:32] = newv; ins_w = 1; end
        default: ;
      endcase
    end
    if (!cyc_w) m_cycle = m_cycle + 64'd1;
    if (!ins_w && instret && !trap) m_instret = m_instret + 64'd1;
    irq_hist.push_front({irq_ext, irq_timer});
    void'(irq_hist.pop_back());
  endtask

  // One clock: compare combinational outputs against the model, then advance both.
  task automatic step(input string tag);
    logic trap, is_irq, redir;
    int code;
    logic [31:0] rpc;
    #1;
    m_expect(trap, is_irq, code, redir, rpc);
    cap_trap = trap_taken; cap_redirect = redirect; cap_rdata = csr_rdata; cap_rpc = redirect_pc;
    check({tag, ".rdata"}, csr_rdata, m_read(csr_addr));
    check({tag, ".trap"}, 32'(trap_taken), 32'(trap));
    check({tag, ".redirect"}, 32'(redirect), 32'(redir));
    if (redir) check({tag, ".rpc"}, redirect_pc, rpc);
    @(posedge clk);
    m_commit();
    #1;
  endtask

  task automatic clear_inputs();
    csr_op = 0; csr_addr = 0; csr_wdata = 0; pc = 0; instret = 0;
    ecall = 0; ebreak = 0; illegal = 0; is_mret = 0; irq_ext = 0; irq_timer = 0;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    csr_op = op; csr_addr = a; csr_wdata = wd;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_op = 0; csr_addr = a; csr_wdata = 0;
  endtask

  task automatic reset_dut();
    logic [11:0] ra [4] = '{12'h342, 12'h341, 12'h300, 12'h305};
    logic [31:0] re [4] = '{32'd0, 32'd0, 32'd0, MTVEC_RST};
    clear_inputs();
    rst = 0;
    #1;
    m_reset();
    check("rst.trap", 32'(trap_taken), 32'd0);
    check("rst.redirect", 32'(redirect), 32'd0);
    for (int i = 0; i < 4; i++) begin
      csr_addr = ra[i];
      #1;
      check($sformatf("rst.rd_%h", ra[i]), csr_rdata, re[i]);
    end
    @(negedge clk);
    #2;
    rst = 1;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    #1;
    reset_dut();

    for (int i = 0; i < 13; i++) begin
      rd(rd_addr[i]);
      step("rd");
      check($sformatf("reset_rd_%0d_%h", i, rd_addr[i]), cap_rdata, rd_exp[i]);
    end

    // Timer interrupt through vectored mtvec.
    csr(2'b10, 12'h304, 32'h80);  step("en_mti");
    csr(2'b10, 12'h300, 32'h8);   step("en_mie");
    csr(2'b01, 12'h305, 32'h101); step("mtvec");
    rd(12'h0); irq_timer = 1; pc = 32'h80;
    step("lat0"); check("irq_lat0", 32'(cap_trap), 32'd0);
    step("lat1"); check("irq_lat1", 32'(cap_trap), 32'd0);
    step("mti");  check("mti_trap", 32'(cap_trap), 32'd1);
    check("mti_vec", cap_rpc, 32'h11C);
    irq_timer = 0;
    rd(12'h342); step("mcause"); check("mti_mcause", cap_rdata, 32'h8000_0007);
    rd(12'h300); step("mstat");  check("mti_mstatus", cap_rdata, 32'h80);

    // Exception priority inside handler, with a CSR write that must be dropped.
    pc = 32'h40; illegal = 1; ecall = 1; csr(2'b01, 12'h340, 32'hDEAD);
    step("exc"); check("exc_trap", 32'(cap_trap), 32'd1); check("exc_vec", cap_rpc, 32'h100);
    illegal = 0; ecall = 0;
    rd(12'h342); step("c2");   check("exc_mcause", cap_rdata, 32'd2);
    rd(12'h341); step("e40");  check("exc_mepc", cap_rdata, 32'h40);
    rd(12'h340); step("scr");  check("dropped_write", cap_rdata, 32'd0);
    rd(12'h300); step("ms0");  check("nested_mpie", cap_rdata, 32'd0);

    // MRET restores MIE from MPIE.
    csr(2'b01, 12'h300, 32'h80); step("w_ms");
    csr(2'b01, 12'h341, 32'h46); step("w_epc");
    rd(12'h341); step("r_epc"); check("mepc_align", cap_rdata, 32'h44);
    rd(12'h0); is_mret = 1;
    step("mret"); check("mret_redirect", 32'(cap_redirect), 32'd1); check("mret_pc", cap_rpc, 32'h44);
    is_mret = 0;
    rd(12'h300); step("ms88"); check("mret_mstatus", cap_rdata, 32'h88);

    // Simultaneous timer and local line 0.
    csr(2'b10, 12'h304, 32'h10000); step("en_l0");
    rd(12'h0); irq_ext = 4'b0001; irq_timer = 1; pc = 32'h200;
    step("s0"); step("s1"); step("both");
    check("both_trap", 32'(cap_trap), 32'd1); check("both_vec", cap_rpc, 32'h11C);
    irq_timer = 0;
    rd(12'h342); step("bc"); check("both_cause", cap_rdata, 32'h8000_0007);
    rd(12'h0); step("idle");
    is_mret = 1; step("mret2"); check("mret2_pc", cap_rpc, 32'h200);
    is_mret = 0; pc = 32'h300;
    step("l0"); check("l0_trap", 32'(cap_trap), 32'd1); check("l0_vec", cap_rpc, 32'h140);
    irq_ext = 0;
    rd(12'h342); step("l0c"); check("l0_cause", cap_rdata, 32'h8000_0010);

    // Field masks, mip read-only, counters.
    csr(2'b11, 12'h304, 32'h80);       step("rc_mie");
    rd(12'h304); step("r_mie");        check("rc_mie", cap_rdata, 32'h10000);
    csr(2'b10, 12'h305, 32'h2);        step("rs_tvec");
    rd(12'h305); step("r_tvec");       check("mtvec_bit1", cap_rdata, 32'h101);
    csr(2'b01, 12'h344, 32'hFFFF_FFFF); step("w_mip");
    rd(12'h344); step("r_mip");        check("mip_ro", cap_rdata, 32'd0);
    csr(2'b01, 12'hB80, 32'h0);        step("w_cych");
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF); step("w_cyc");
    rd(12'hB00); step("cyc_ff");       check("cyc_write_wins", cap_rdata, 32'hFFFF_FFFF);
    rd(12'hB00); step("cyc_lo");       check("cyc_carry_lo", cap_rdata, 32'd0);
    rd(12'hB80); step("cyc_hi");       check("cyc_carry_hi", cap_rdata, 32'd1);
    csr(2'b01, 12'hB80, 32'hFFFF_FFFF); step("w_cych2");
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF); step("w_cyc2");
    rd(12'hB00); step("wrap");
    rd(12'hB80); step("wrap_hi");      check("cyc_wrap64", cap_rdata, 32'd0);
    instret = 1; csr(2'b01, 12'hB02, 32'd5); step("w_ins");
    rd(12'hB02); instret = 1; ecall = 1; step("ins_trap"); check("instret_write_wins", cap_rdata, 32'd5);
    instret = 0; ecall = 0;
    rd(12'hB02); step("ins_r");        check("instret_no_inc_trap", cap_rdata, 32'd5);

    // Reset asserted while a handler is active.
    ecall = 1; pc = 32'h500; step("pre_rst");
    reset_dut();

    for (int n = 0; n < 400; n++) begin
      csr_op    = 2'($urandom_range(0, 3));
      csr_addr  = rnd_addr[$urandom_range(0, 13)];
      csr_wdata = $urandom;
      pc        = $urandom;
      instret   = 1'($urandom_range(0, 1));
      illegal   = ($urandom_range(0, 11) == 0);
      ebreak    = ($urandom_range(0, 11) == 0);
      ecall     = ($urandom_range(0, 11) == 0);
      is_mret   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) irq_timer = ~irq_timer;
      if ($urandom_range(0, 3) == 0) irq_ext = irq_ext ^ 4'(1 << $urandom_range(0, 3));
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Parametrised machine-mode CSR and trap controller for the single-cycle RV32 core; successor to the current `csr` block. Adds vectored trap entry, `NUM_IRQ` synchronised local interrupts plus a timer interrupt, synchronous exceptions, and 64-bit `mcycle`/`minstret` counters. It sits beside the register file and drives the PC mux's trap/`mret` redirect.

## Interface
- `XLEN`, 32, data/address width.
- `NUM_IRQ`, 4, local interrupt lines (1..16), mapped to cause codes 16..16+NUM_IRQ-1.
- `MTVEC_RESET`, 32'h0, reset value of `mtvec`.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `csr_op` in 2: 00 none, 01 RW, 10 RS (set), 11 RC (clear).
- `csr_addr` in 12: CSR address.
- `csr_wdata` in XLEN: rs1 value or zero-extended uimm.
- `csr_rdata` out XLEN: pre-update value of addressed CSR; 0 if unimplemented.
- `pc` in XLEN: PC of instruction in this cycle.
- `instret` in 1: current instruction retires.
- `ecall`, `ebreak`, `illegal` in 1 each: synchronous exceptions of current instruction.
- `is_mret` in 1: current instruction is MRET.
- `irq_ext` in NUM_IRQ: asynchronous, level-sensitive local interrupts.
- `irq_timer` in 1: asynchronous, level-sensitive timer interrupt.
- `trap_taken` out 1: trap this cycle; core suppresses rf/mem/CSR writes.
- `redirect` out 1: `trap_taken | mret_taken`.
- `redirect_pc` out XLEN: next PC when `redirect`.

## Operation
- CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, other bits read 0), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only), mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
- Write value: RW = wdata; RS = old|wdata; RC = old&~wdata. Unimplemented addresses or writes to mip: ignored, read 0.
- mtvec bit1 forced 0; mepc bits[1:0] forced 0; mie writable only on bits 7 and 16..16+NUM_IRQ-1.
- mip: bit7 = synchronised `irq_timer`, bit 16+i = synchronised `irq_ext[i]`.
- Interrupt pending = mip & mie & mstatus.MIE. Priority: MTI (7) highest, then local 16 upward.
- Trap priority: interrupt > illegal (cause 2) > ebreak (3) > ecall (11). Interrupt squashes the instruction at `pc`.
- Trap entry at the edge: mepc <= pc; mcause <= {interrupt, code}; MPIE <= MIE; MIE <= 0.
- `redirect_pc` on trap: mtvec.mode=0 or exception -> {mtvec[XLEN-1:2],2'b00}; mode=1 and interrupt -> base + 4*code.
- MRET (`is_mret` and no trap): MIE <= MPIE, MPIE <= 1, `redirect_pc` = mepc.
- mcycle increments every cycle; minstret increments when `instret & ~trap_taken`.

## Timing
- Reset: all CSRs 0 except mtvec = MTVEC_RESET; sync flops 0; counters 0; `trap_taken`/`redirect` 0.
- `csr_rdata`, `trap_taken`, `redirect`, `redirect_pc`: combinational, same cycle. State updates on the next edge.
- IRQ latency: input high -> mip visible 2 edges later; `trap_taken` same cycle if enabled.
- Trap and CSR write in the same cycle: CSR write dropped.
- Trap and `is_mret` in the same cycle: trap wins, MRET has no effect.
- CSR write to a counter in a cycle where it would increment: write wins, no increment. 64-bit wrap to 0.
- Trap with MIE already 0 (exception inside handler): MPIE <= 0; nesting is not otherwise supported.
- Reset mid-handler: state cleared immediately, asynchronously.

## Structure
- `csr_pkg`: CSR address localparams, `csr_op_e` enum, cause-code constants, mstatus bit indices.
- Sub-module `irq_sync`: parametrised-width 2-flop synchroniser with asynchronous active-low reset; one instance of width NUM_IRQ+1.

## Test plan
- Reset then read each CSR -> mtvec = MTVEC_RESET, all others 0; mcycle = 3 after 3 edges.
- csr_op=RS mie 0x80, RS mstatus 0x8, mtvec=0x101 (vectored), raise `irq_timer` -> `trap_taken` 2 edges later, redirect_pc 0x11C, mcause 0x8000_0007, MIE 0, MPIE 1.
- `illegal` and `ecall` both high, pc=0x40 -> mcause 2, mepc 0x40, redirect_pc = mtvec base.
- MRET with mepc 0x44 -> redirect_pc 0x44, MIE restored to 1, MPIE 1.
- `irq_ext[0]` and `irq_timer` simultaneous, both enabled -> cause 7; after timer cleared and MRET, cause 16 taken.
- mcycle = 0xFFFF_FFFF (mcycleh 0), one edge -> mcycle 0, mcycleh 1. CSR write during a trap cycle -> target unchanged.
